// File: rtl/maxnet_engine_if.sv
// Load/result handshake bundle for maxnet_engine: activation beats in, winner report out.
// The master side is the producer/consumer pair; the slave side is the engine.
interface maxnet_engine_if #(
    parameter int N        = 4,
    parameter int W        = 5,
    parameter int MAX_ITER = 31
);
    localparam int IW  = $clog2(N);
    localparam int ITW = $clog2(MAX_ITER + 1);

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   max_value;
    logic [IW-1:0]  max_index;
    logic           tie;
    logic           timeout;
    logic [ITW-1:0] iterations;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, max_value, max_index, tie, timeout, iterations
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, max_value, max_index, tie, timeout, iterations
    );
endinterface

// File: rtl/maxnet_engine.sv
// MaxNet winner-take-all: loads N activations serially, iterates lateral inhibition
// (MULT/SUM/CHECK) until one survivor, all die (tie) or the iteration limit hits (timeout).
module maxnet_engine #(
    parameter int N        = 4,
    parameter int W        = 5,
    parameter int EPS      = 1,
    parameter int EPS_FRAC = 2,
    parameter int MAX_ITER = 31
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    maxnet_engine_if.slave bus,
    output logic         busy_o
);
    localparam int IW  = $clog2(N);
    localparam int ITW = $clog2(MAX_ITER + 1);
    localparam int SW  = W + IW;
    localparam int EW  = $clog2(EPS + 1);
    localparam int PW  = SW + EW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MULT,
        S_SUM,
        S_DONE
    } state_e;

    state_e         state_q;
    logic [W-1:0]   x_q [N];
    logic [W-1:0]   y_q [N];
    logic [PW-1:0]  p_q [N];
    logic [N-1:0]   prev_mask_q;
    logic [IW-1:0]  beat_q;
    logic [ITW-1:0] iter_q;

    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;
    logic [W-1:0]   max_value_q;
    logic [IW-1:0]  max_index_q;
    logic           tie_q;
    logic           timeout_q;
    logic [ITW-1:0] iterations_q;

    logic [SW-1:0]  total_d;
    logic [N-1:0]   mask_d;
    logic [PW-1:0]  p_d [N];
    logic [W-1:0]   y_d [N];
    logic [IW-1:0]  lo_mask_d;
    logic [IW-1:0]  lo_prev_d;
    logic           single_d;

    // p = floor(S * EPS / 2^EPS_FRAC); kept wide since EPS may exceed 2^EPS_FRAC.
    function automatic logic [PW-1:0] inhibit(input logic [SW-1:0] s);
        logic [PW-1:0] prod;
        prod = PW'(s) * PW'(EPS);
        return prod >> EPS_FRAC;
    endfunction

    function automatic logic [W-1:0] decay(input logic [W-1:0] y, input logic [PW-1:0] p);
        if (PW'(y) > p) return y - W'(p);
        return '0;
    endfunction

    function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] m);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        total_d = '0;
        mask_d  = '0;
        for (int i = 0; i < N; i++) begin
            total_d   = total_d + SW'(y_q[i]);
            mask_d[i] = (y_q[i] != '0);
        end
        for (int i = 0; i < N; i++) begin
            p_d[i] = inhibit(total_d - SW'(y_q[i]));
            y_d[i] = decay(y_q[i], p_q[i]);
        end
        lo_mask_d = lowest_set(mask_d);
        lo_prev_d = lowest_set(prev_mask_q);
        single_d  = (mask_d != '0) && ((mask_d & (mask_d - N'(1))) == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                p_q[i] <= '0;
            end
            prev_mask_q  <= '0;
            beat_q       <= '0;
            iter_q       <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            max_value_q  <= '0;
            max_index_q  <= '0;
            tie_q        <= 1'b0;
            timeout_q    <= 1'b0;
            iterations_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        x_q[beat_q] <= bus.in_data;
                        y_q[beat_q] <= bus.in_data;
                        if (beat_q == IW'(N - 1)) begin
                            beat_q      <= '0;
                            iter_q      <= '0;
                            prev_mask_q <= '0;
                            in_ready_q  <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= S_CHECK;
                        end else begin
                            beat_q <= beat_q + IW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (single_d) begin
                        max_index_q  <= lo_mask_d;
                        tie_q        <= 1'b0;
                        timeout_q    <= 1'b0;
                        iterations_q <= iter_q;
                        state_q      <= S_DONE;
                    end else if (mask_d == '0) begin
                        // Everyone died together: report the first of the last live set.
                        max_index_q  <= lo_prev_d;
                        tie_q        <= 1'b1;
                        timeout_q    <= 1'b0;
                        iterations_q <= iter_q;
                        state_q      <= S_DONE;
                    end else if (iter_q == ITW'(MAX_ITER)) begin
                        max_index_q  <= lo_mask_d;
                        tie_q        <= 1'b0;
                        timeout_q    <= 1'b1;
                        iterations_q <= iter_q;
                        state_q      <= S_DONE;
                    end else begin
                        prev_mask_q <= mask_d;
                        state_q     <= S_MULT;
                    end
                end
                S_MULT: begin
                    for (int i = 0; i < N; i++) p_q[i] <= p_d[i];
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    for (int i = 0; i < N; i++) y_q[i] <= y_d[i];
                    iter_q  <= iter_q + ITW'(1);
                    state_q <= S_CHECK;
                end
                S_DONE: begin
                    // First DONE cycle fetches the original value; valid rises with it.
                    if (!out_valid_q) begin
                        max_value_q <= x_q[max_index_q];
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.max_value  = max_value_q;
    assign bus.max_index  = max_index_q;
    assign bus.tie        = tie_q;
    assign bus.timeout    = timeout_q;
    assign bus.iterations = iterations_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_maxnet_engine.sv
// Bench for maxnet_engine: two instances (eps=1/4 and eps=1), directed and random jobs
// compared against a plain-arithmetic MaxNet reference model.
module tb_maxnet_engine;
    localparam int N = 4;
    localparam int W = 5;
    localparam int MAX_ITER = 31;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic         busy_a, busy_b;

    maxnet_engine_if #(.N(N), .W(W), .MAX_ITER(MAX_ITER)) ifa ();
    maxnet_engine_if #(.N(N), .W(W), .MAX_ITER(MAX_ITER)) ifb ();

    assign ifa.in_valid  = (sel == 0) ? in_valid : 1'b0;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = (sel == 0) ? out_ready : 1'b0;
    assign ifb.in_valid  = (sel == 1) ? in_valid : 1'b0;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = (sel == 1) ? out_ready : 1'b0;

    logic         o_in_ready, o_out_valid, o_tie, o_timeout, o_busy;
    logic [W-1:0] o_max_value;
    logic [1:0]   o_max_index;
    logic [4:0]   o_iterations;
    assign o_in_ready   = (sel == 0) ? ifa.in_ready   : ifb.in_ready;
    assign o_out_valid  = (sel == 0) ? ifa.out_valid  : ifb.out_valid;
    assign o_max_value  = (sel == 0) ? ifa.max_value  : ifb.max_value;
    assign o_max_index  = (sel == 0) ? ifa.max_index  : ifb.max_index;
    assign o_tie        = (sel == 0) ? ifa.tie        : ifb.tie;
    assign o_timeout    = (sel == 0) ? ifa.timeout    : ifb.timeout;
    assign o_iterations = (sel == 0) ? ifa.iterations : ifb.iterations;
    assign o_busy       = (sel == 0) ? busy_a         : busy_b;

    maxnet_engine #(.N(N), .W(W), .EPS(1), .EPS_FRAC(2), .MAX_ITER(MAX_ITER)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifa),
        .busy_o(busy_a)
    );

    maxnet_engine #(.N(N), .W(W), .EPS(4), .EPS_FRAC(2), .MAX_ITER(MAX_ITER)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifb),
        .busy_o(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] pack(input int a, input int b, input int c, input int d);
        logic [4:0] va, vb, vc, vd;
        va = a[4:0]; vb = b[4:0]; vc = c[4:0]; vd = d[4:0];
        return {vd, vc, vb, va};
    endfunction

    // Reference: repeat y_i := max(0, y_i - floor(eps*(sum_{j!=i} y_j))) until decided.
    function automatic void model(input int s, input logic [19:0] vals,
                                  output int idx, output int val, output int tie,
                                  output int to, output int it);
        int y[4];
        int p[4];
        int eps, cnt, lo, prev_lo, total;
        eps = (s == 0) ? 1 : 4;
        for (int k = 0; k < 4; k++) y[k] = int'(vals[k*5 +: 5]);
        it = 0; prev_lo = 0; idx = 0; tie = 0; to = 0;
        for (int guard = 0; guard <= MAX_ITER + 1; guard++) begin
            cnt = 0; lo = -1; total = 0;
            for (int k = 0; k < 4; k++) begin
                total += y[k];
                if (y[k] != 0) begin
                    cnt++;
                    if (lo < 0) lo = k;
                end
            end
            if (cnt == 1) begin idx = lo; break; end
            if (cnt == 0) begin idx = prev_lo; tie = 1; break; end
            if (it == MAX_ITER) begin idx = lo; to = 1; break; end
            prev_lo = lo;
            for (int k = 0; k < 4; k++) p[k] = ((total - y[k]) * eps) >> 2;
            for (int k = 0; k < 4; k++) y[k] = (y[k] > p[k]) ? y[k] - p[k] : 0;
            it++;
        end
        val = int'(vals[idx*5 +: 5]);
    endfunction

    task automatic load_job(input int s, input logic [19:0] vals, input bit gaps,
                            output int t_last);
        sel = s;
        t_last = 0;
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            check("in_ready_idle", o_in_ready, 1);
            in_valid = 1'b1;
            in_data  = vals[k*5 +: 5];
            @(posedge clk);
            #1;
            t_last = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int s, input logic [19:0] vals, input bit gaps, input bit noise,
                           input int hold, input bit pre_ready,
                           input int e_idx, input int e_val, input int e_tie,
                           input int e_to, input int e_it);
        int ei, ev, et, eo, ek, t_last, w;
        bit seen;
        if (e_idx < 0) model(s, vals, ei, ev, et, eo, ek);
        else begin
            ei = e_idx; ev = e_val; et = e_tie; eo = e_to; ek = e_it;
        end
        load_job(s, vals, gaps, t_last);
        out_ready = pre_ready;
        seen = 1'b0;
        w = 0;
        while (w < 150) begin
            @(negedge clk);
            if (w == 0) begin
                check("busy_running", o_busy, 1);
                check("in_ready_running", o_in_ready, 0);
            end
            if (o_out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (noise) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
            end
            w++;
        end
        in_valid = 1'b0;
        check("result_arrived", seen, 1);
        if (seen) begin
            check("latency", cyc - t_last, 2 + 3 * ek);
            check("max_index", o_max_index, ei);
            check("max_value", o_max_value, ev);
            check("tie", o_tie, et);
            check("timeout", o_timeout, eo);
            check("iterations", o_iterations, ek);
            if (!pre_ready) begin
                repeat (hold) begin
                    @(negedge clk);
                    check("hold_valid", o_out_valid, 1);
                    check("hold_index", o_max_index, ei);
                    check("hold_value", o_max_value, ev);
                    check("hold_flags", {o_tie, o_timeout}, {et[0], eo[0]});
                    check("hold_iter", o_iterations, ek);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            check("valid_cleared", o_out_valid, 0);
            check("in_ready_after", o_in_ready, 1);
            check("busy_after", o_busy, 0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int t;
        logic [19:0] v;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        sel = 0;
        check("rst_in_ready", o_in_ready, 1);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_value", o_max_value, 0);
        check("rst_index", o_max_index, 0);
        check("rst_flags", {o_tie, o_timeout}, 0);
        check("rst_iter", o_iterations, 0);
        sel = 1;
        check("rst_b_in_ready", o_in_ready, 1);
        check("rst_b_busy", o_busy, 0);
        sel = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_job(0, pack(10, 20, 5, 15), 0, 0, 0, 1, 1, 20, 0, 0, 4);
        run_job(0, pack(0, 0, 9, 0),    1, 1, 5, 0, 2, 9, 0, 0, 0);
        run_job(0, pack(7, 7, 0, 0),    0, 1, 0, 0, 0, 7, 0, 1, 31);
        run_job(1, pack(9, 9, 0, 0),    0, 0, 2, 0, 0, 9, 1, 0, 1);
        run_job(1, pack(0, 0, 0, 0),    1, 0, 0, 1, 0, 0, 1, 0, 0);
        run_job(0, pack(10, 20, 5, 15), 0, 0, 0, 0, 1, 20, 0, 0, 4);

        // Reset lands mid-SUM and between clock edges; the partial job must vanish.
        load_job(0, pack(3, 30, 30, 1), 0, t);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_in_ready", o_in_ready, 1);
        check("arst_out_valid", o_out_valid, 0);
        check("arst_busy", o_busy, 0);
        check("arst_value", o_max_value, 0);
        check("arst_index", o_max_index, 0);
        check("arst_flags", {o_tie, o_timeout}, 0);
        check("arst_iter", o_iterations, 0);
        #3 rst_n = 1'b1;
        run_job(0, pack(10, 20, 5, 15), 1, 0, 1, 0, 1, 20, 0, 0, 4);

        for (int r = 0; r < 24; r++) begin
            int s;
            s = int'($urandom_range(0, 1));
            v = pack(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) v[9:5] = v[4:0];
            if ($urandom_range(0, 4) == 0) v[19:10] = '0;
            run_job(s, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), -1, 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/maxnet_engine.md
# maxnet_engine

Parametrised MaxNet winner-take-all engine: accepts N unsigned W-bit activations over a serial valid/ready stream and iterates the lateral-inhibition update until one activation survives. It reports the winner's original value and index, plus tie/timeout status and the iteration count, over a held valid/ready result port. It supersedes the fixed 4×5-bit MaxNet and sits between the feature-score producer and the classification consumer.

## Interface
- N, 4, channel count (≥2)
- W, 5, activation width (bits)
- EPS, 1, inhibition numerator; ε = EPS / 2^EPS_FRAC
- EPS_FRAC, 2, inhibition fraction bits
- MAX_ITER, 31, iteration limit (≥1)
- IW = $clog2(N), ITW = $clog2(MAX_ITER+1) (derived, not overridable)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (single clock domain)
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beats (IDLE only)
- in_data  in  W  activation; beat k loads channel k (k = 0..N-1)
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- max_value  out  W  original input value of the winning channel
- max_index  out  IW  winning channel index
- tie  out  1  all activations reached zero simultaneously
- timeout  out  1  MAX_ITER reached without a single survivor
- iterations  out  ITW  update iterations performed
- busy  out  1  high in every state except IDLE

## Operation
- Registers: x[N] (original inputs), y[N] (activations), p[N] (inhibition), prev_mask[N], beat counter, iteration counter.
- States: IDLE, CHECK, MULT, SUM, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: x[k]<=in_data, y[k]<=in_data, k++. After beat N-1 is accepted: k<=0, iter<=0, go to CHECK.
- CHECK: mask[i] = (y[i]!=0). Priority:
  - popcount(mask)==1 -> DONE; index = set bit; tie=0, timeout=0.
  - mask==0 -> DONE, tie=1; index = lowest set bit of prev_mask (0 if no iteration has run).
  - iter==MAX_ITER -> DONE, timeout=1; index = lowest set bit of mask.
  - otherwise prev_mask<=mask, go to MULT.
- MULT: T = Σy; S_i = T − y_i (width W+IW, no overflow); p_i <= (S_i·EPS) >> EPS_FRAC (truncating). -> SUM.
- SUM: y_i <= (y_i > p_i) ? y_i − p_i : 0; iter++. -> CHECK.
- DONE: out_valid=1; max_value = x[index]; all result outputs are registered and stable while out_valid=1. On out_ready, go to IDLE next cycle.
- in_valid outside IDLE is ignored (in_ready=0); input data is never dropped silently.
- x is unchanged after load; y is modified only in SUM.

## Timing
- Reset (async, reset=0): state=IDLE, in_ready=1, out_valid=0, busy=0, max_value=0, max_index=0, tie=0, timeout=0, iterations=0; counters, x, y, p, and prev_mask are cleared. Reset takes effect immediately mid-load or mid-iteration, and the partial job is discarded.
- Load: N accepted beats, with back-to-back beats allowed (1 beat/cycle max) and gaps allowed.
- Each iteration takes 3 cycles (MULT, SUM, CHECK).
- Latency: the last beat is accepted at edge T; CHECK occurs in cycle T+1; with k iterations, out_valid rises at edge T+2+3k.
- Result handshake: the transfer completes on the cycle where out_valid&&out_ready; in_ready=1 on the following cycle. out_ready held high in advance completes DONE in 1 cycle.
- out_ready outside DONE is ignored.

## Test plan
- Defaults; beats 10,20,5,15 -> y evolves (0,13,0,7),(0,12,0,4),(0,11,0,1),(0,11,0,0); out_valid at T+14; max_index=1, max_value=20, iterations=4, tie=0, timeout=0.
- Defaults; beats 0,0,9,0 -> single survivor at first CHECK; out_valid at T+2; max_index=2, max_value=9, iterations=0.
- Defaults; beats 7,7,0,0 -> y settles at (3,3,0,0); timeout=1, iterations=31, max_index=0, max_value=7, out_valid at T+95.
- EPS=4, EPS_FRAC=2; beats 9,9,0,0 -> both reach zero after iteration 1; tie=1, max_index=0, max_value=9, iterations=1. With beats 0,0,0,0 -> tie=1, iterations=0, max_index=0, max_value=0.
- Handshake: in_valid toggled with gaps during load; in_valid asserted during iteration and ignored; out_ready held low 5 cycles in DONE, with outputs stable throughout; out_ready=1 returns the engine to IDLE the next cycle; a second job runs correctly back-to-back.
- Async reset: assert reset=0 mid-SUM for a non-edge-aligned interval -> all outputs take reset values immediately; the next full load produces the correct fresh result.
